// File: rtl/aes_key_mem_ext.sv
// AES-128/256 round-key expansion memory: one round key per cycle into key_mem, combinational read port.
// Ready 13 (AES-128) or 17 (AES-256) cycles after init; init is ignored while busy.
module aes_key_mem_ext #(
  parameter bit AES_256_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic         init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic         busy,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  localparam int DEPTH = AES_256_EN ? 15 : 11;

  typedef enum logic [1:0] {IDLE, INIT, GENERATE, DONE} state_t;

  state_t         state, state_nxt;
  logic [127:0]   key_mem [DEPTH];
  logic [255:0]   key_reg;
  logic           mode_reg;
  logic [127:0]   prev0, prev1;
  logic [3:0]     round_ctr;
  logic [7:0]     rcon;
  logic           ready_reg;
  logic [3:0]     last_round;
  logic [31:0]    t, k0, k1, k2, k3;
  logic [127:0]   base, new_key;
  logic           rcon_step;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  assign last_round = mode_reg ? 4'd14 : 4'd10;
  assign sboxw      = prev1[31:0];
  assign ready      = ready_reg;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (init) state_nxt = INIT;
      INIT:     state_nxt = GENERATE;
      GENERATE: if (round_ctr == last_round) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // AES-256 odd rounds substitute without rotation or rcon; both modes chain from the key two/one writes back.
  always_comb begin
    t         = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon, 24'h0};
    base      = prev1;
    rcon_step = 1'b1;
    if (mode_reg) begin
      base = prev0;
      if (round_ctr[0]) begin
        t         = new_sboxw;
        rcon_step = 1'b0;
      end
    end
    k0 = base[127:96] ^ t;
    k1 = base[95:64]  ^ k0;
    k2 = base[63:32]  ^ k1;
    k3 = base[31:0]   ^ k2;
    if (round_ctr == 4'd0)
      new_key = key_reg[255:128];
    else if (mode_reg && (round_ctr == 4'd1))
      new_key = key_reg[127:0];
    else
      new_key = {k0, k1, k2, k3};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) key_mem[i] <= '0;
      key_reg   <= '0;
      mode_reg  <= 1'b0;
      prev0     <= '0;
      prev1     <= '0;
      round_ctr <= '0;
      rcon      <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            key_reg   <= key;
            mode_reg  <= keylen & AES_256_EN;
            ready_reg <= 1'b0;
          end
        end
        INIT: begin
          round_ctr <= '0;
          rcon      <= 8'h8d;
        end
        GENERATE: begin
          for (int i = 0; i < DEPTH; i++)
            if (round_ctr == 4'(i)) key_mem[i] <= new_key;
          prev0     <= prev1;
          prev1     <= new_key;
          round_ctr <= round_ctr + 4'd1;
          if (rcon_step) rcon <= xtime(rcon);
        end
        DONE: ready_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  // Entries above the latched mode's last round read as zero even if stale.
  always_comb begin
    round_key = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((round == 4'(i)) && (round <= last_round)) round_key = key_mem[i];
  end

endmodule

// File: doc/aes_key_mem_ext.md
# aes_key_mem_ext

Parametrised AES round-key expansion memory supporting AES-128 and AES-256 key lengths, selected per `init`. It expands the cipher key into 11 or 15 round keys, one round key per cycle, and stores them in an internal memory. The memory is read combinationally by the encipher/decipher datapath. The S-box is external and shared with the round datapath through a combinational word-lookup port.

## Interface
- `AES_256_EN`, default 1: when 1, memory depth is 15 and `keylen` is honoured; when 0, memory depth is 11, `keylen` is ignored (treated as 0), and `key[127:0]` is unused.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: reset is asynchronous, active-low.
- `key` in 256: cipher key. AES-128 uses `key[255:128]`.
- `keylen` in 1: 0 = AES-128 (N = 10), 1 = AES-256 (N = 14).
- `init` in 1: start expansion. Single-cycle or level; sampled only in IDLE.
- `round` in 4: round-key read index.
- `round_key` out 128: `key_mem[round]`, combinational. Reads 0 when `round` > N of the latched mode.
- `ready` out 1: high when the memory holds a complete schedule.
- `busy` out 1: high while the FSM is not in IDLE.
- `sboxw` out 32: word to substitute.
- `new_sboxw` in 32: bytewise S-box of `sboxw`, same cycle.

## Operation
- FSM states: IDLE, INIT, GENERATE, DONE.
- **IDLE**
  - If `init`=1 at an edge: latch `key` → `key_reg` and `keylen` → `mode_reg`, clear `ready`, go to INIT.
  - `init` in any other state is ignored; the latched key and mode are not changed.
- **INIT**: `round_ctr` ← 0, `rcon` ← 8'h8d, go to GENERATE.
- **GENERATE**: each cycle writes `key_mem[round_ctr]`, then `round_ctr`++. When `round_ctr` == N (the last write), go to DONE.
- **DONE**: `ready` ← 1, go to IDLE.
- `prev1` = last written key; `prev0` = the key written before it. Words of a key are w0..w3, MSB first.
- `sboxw` = `prev1.w3` at all times. `rcon_next` = xtime(`rcon`) = {`rcon`[6:0],0} ^ (8'h1b & {8{`rcon`[7]}}).
- **AES-128**
  - Round 0: write `key_reg[255:128]`; rcon advances (8d→01).
  - Round r ≥ 1: t = rot8L(`new_sboxw`) ^ {`rcon`,24'h0}, then k0 = `prev1.w0` ^ t, ki = k(i-1) ^ `prev1.wi`. Rcon advances.
- **AES-256**
  - Round 0: write `key_reg[255:128]`; rcon advances (8d→01).
  - Round 1: write `key_reg[127:0]`; rcon holds.
  - Even r ≥ 2: t = rot8L(`new_sboxw`) ^ {`rcon`,24'h0}; rcon advances.
  - Odd r ≥ 3: t = `new_sboxw` (no rotation, no rcon); rcon holds.
  - k0 = `prev0.w0` ^ t, ki = k(i-1) ^ `prev0.wi`.
- Rcon sequence consumed: 01,02,04,08,10,20,40,80,1b,36 for AES-128 rounds 1..10; 01..40 for AES-256 rounds 2,4,..,14.
- Re-init after completion overwrites all entries 0..N. In AES-256 builds, entries above N are left unchanged but read as 0 via the range check.
- Reads of `round_key` during GENERATE return whatever is currently stored. Consumers must wait for `ready`.

## Timing
- Reset values: `ready`=0, `busy`=0, `round_key`=0 for all `round`, `sboxw`=0. Reset also clears all memory entries, `prev0`, `prev1`, `key_reg`, `round_ctr`, `rcon`(=0) and `mode_reg`(=0), and forces the state to IDLE.
- `init` sampled at edge E0. `busy` rises after E0. GENERATE writes occur at edges E2..E(N+2). `ready` rises and `busy` falls after E(N+3).
  - AES-128: `ready` rises 13 cycles after the `init` edge.
  - AES-256: `ready` rises 17 cycles after the `init` edge.
- `ready` falls one cycle after a new `init` is accepted.
- `reset_n` low mid-expansion: immediate return to reset values. `init` must be reasserted.
- `init` held high continuously restarts expansion from every IDLE; `ready` pulses high for one cycle each time.
- `new_sboxw` must settle within the same cycle as `sboxw`. There is no pipelining of the S-box path.

## Test plan
- **AES-128 vector**: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, `keylen`=0, `init` pulse.
  - `ready` rises after 13 cycles.
  - round 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - round 11 reads 0.
- **AES-256 vector**: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, `keylen`=1.
  - `ready` rises after 17 cycles.
  - round 2 = 9ba35411 8e6925af a51a8b5f 2067fcde.
  - round 14 = fe4890d1 e6188d0b 046df344 706c631e.
- **Busy-ignore**: while generating AES-128, assert `init` with a different key and `keylen`=1.
  - Schedule matches the first key.
  - `ready` still rises at cycle 13.
- **Mode switch**: complete AES-256, then re-init AES-128 with the vector above.
  - Rounds 0..10 match the AES-128 vector.
  - Round 12 reads 0.
- **Reset mid-operation**: drop `reset_n` in cycle 6 of expansion.
  - `ready`=0, `busy`=0, all rounds read 0.
  - A fresh `init` yields the correct schedule.
- **AES_256_EN=0 build**: `keylen`=1 with the AES-128 key.
  - Produces the AES-128 schedule.
  - `ready` rises after 13 cycles.
